// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom pipeline: default frame limits, raster
// counter widths and the frame-buffer writer state encoding.
package zoom_pkg;

   localparam int FBW_MAX_WIDTH  = 640;
   localparam int FBW_MAX_HEIGHT = 480;
   localparam int X_W            = 10;
   localparam int Y_W            = 9;

   typedef enum logic [1:0] {
      FBW_IDLE,
      FBW_WAIT_SOF,
      FBW_WRITE,
      FBW_DONE
   } fbw_state_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Raster x/y position and row base address for the frame-buffer writer.
// Line starts advance by STRIDE each row, so no multiplier is needed.
module raster_addr_gen
   import zoom_pkg::*;
#(
   parameter int ADDR_WIDTH = 19,
   parameter int STRIDE     = 640,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  step,
   input  logic                  resync,
   input  logic [X_W-1:0]        frame_w,
   input  logic [Y_W-1:0]        frame_h,
   output logic [X_W-1:0]        x,
   output logic [Y_W-1:0]        y,
   output logic [ADDR_WIDTH-1:0] row_base,
   output logic                  last_col,
   output logic                  last_pix
);

   logic [X_W-1:0]        r_x;
   logic [Y_W-1:0]        r_y;
   logic [ADDR_WIDTH-1:0] r_row_base;
   logic                  w_single_col;

   assign w_single_col = (frame_w == X_W'(1));
   assign last_col     = (r_x == frame_w - X_W'(1));
   assign last_pix     = last_col && (r_y == frame_h - Y_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x        <= '0;
         r_y        <= '0;
         r_row_base <= '0;
      end else if (clear) begin
         r_x        <= '0;
         r_y        <= '0;
         r_row_base <= ADDR_WIDTH'(BASE_ADDR);
      end else if (resync) begin
         // Resync beat occupies (0,0); continue from the pixel after it.
         r_x        <= w_single_col ? X_W'(0) : X_W'(1);
         r_y        <= w_single_col ? Y_W'(1) : Y_W'(0);
         r_row_base <= w_single_col ? ADDR_WIDTH'(BASE_ADDR + STRIDE)
                                    : ADDR_WIDTH'(BASE_ADDR);
      end else if (step) begin
         if (last_col) begin
            r_x        <= '0;
            r_y        <= r_y + Y_W'(1);
            r_row_base <= r_row_base + ADDR_WIDTH'(STRIDE);
         end else begin
            r_x <= r_x + X_W'(1);
         end
      end
   end

   assign x        = r_x;
   assign y        = r_y;
   assign row_base = r_row_base;

endmodule

// File: rtl/frame_buffer_writer.sv
// Stream-to-memory writer: lands a valid/ready raster pixel stream row-major
// into a single-port frame buffer with a fixed row pitch.
module frame_buffer_writer
   import zoom_pkg::*;
#(
   parameter int MAX_WIDTH  = FBW_MAX_WIDTH,
   parameter int MAX_HEIGHT = FBW_MAX_HEIGHT,
   parameter int STRIDE     = 640,
   parameter int BASE_ADDR  = 0,
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [X_W-1:0]        frame_w,
   input  logic [Y_W-1:0]        frame_h,
   input  logic [DATA_WIDTH-1:0] pix_data,
   input  logic                  pix_valid,
   input  logic                  pix_sof,
   output logic                  pix_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  sync_err
);

   fbw_state_t            r_state;
   fbw_state_t            w_next;
   logic [X_W-1:0]        r_w;
   logic [Y_W-1:0]        r_h;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_sync_err;

   logic                  w_accept;
   logic                  w_dims_ok;
   logic                  w_start_ok;
   logic                  w_write;
   logic                  w_resync;
   logic                  w_step;
   logic [X_W-1:0]        w_x;
   logic [Y_W-1:0]        w_y;
   logic [ADDR_WIDTH-1:0] w_row_base;
   logic                  w_last_col;
   logic                  w_last_pix;

   assign w_accept   = pix_valid & pix_ready;
   assign w_dims_ok  = (frame_w != '0) && (32'(frame_w) <= 32'(MAX_WIDTH)) &&
                       (frame_h != '0) && (32'(frame_h) <= 32'(MAX_HEIGHT));
   assign w_start_ok = (r_state == FBW_IDLE) && start && w_dims_ok;
   assign w_resync   = (r_state == FBW_WRITE) && w_accept && pix_sof;
   assign w_write    = w_accept && ((r_state == FBW_WRITE) ||
                                    ((r_state == FBW_WAIT_SOF) && pix_sof));
   assign w_step     = w_write && !w_resync;

   raster_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .STRIDE     (STRIDE),
      .BASE_ADDR  (BASE_ADDR)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .clear    (w_start_ok),
      .step     (w_step),
      .resync   (w_resync),
      .frame_w  (r_w),
      .frame_h  (r_h),
      .x        (w_x),
      .y        (w_y),
      .row_base (w_row_base),
      .last_col (w_last_col),
      .last_pix (w_last_pix)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= FBW_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FBW_IDLE:     if (w_start_ok) w_next = FBW_WAIT_SOF;
         FBW_WAIT_SOF: if (w_accept && pix_sof)
                          w_next = w_last_pix ? FBW_DONE : FBW_WRITE;
         FBW_WRITE:    if (w_accept && !pix_sof && w_last_pix) w_next = FBW_DONE;
         FBW_DONE:     w_next = FBW_IDLE;
         default:      w_next = FBW_IDLE;
      endcase
   end

   always_comb begin
      pix_ready  = 1'b0;
      busy       = (r_state != FBW_IDLE);
      frame_done = 1'b0;
      case (r_state)
         FBW_WAIT_SOF: pix_ready  = 1'b1;
         FBW_WRITE:    pix_ready  = 1'b1;
         FBW_DONE:     frame_done = 1'b1;
         default:      ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w         <= '0;
         r_h         <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_sync_err  <= 1'b0;
      end else begin
         r_mem_we <= w_write;
         if (w_start_ok) begin
            r_w <= frame_w;
            r_h <= frame_h;
         end
         if (w_write) begin
            r_mem_addr  <= w_resync ? ADDR_WIDTH'(BASE_ADDR)
                                    : w_row_base + ADDR_WIDTH'(w_x);
            r_mem_wdata <= pix_data;
         end
         if (w_start_ok)    r_sync_err <= 1'b0;
         else if (w_resync) r_sync_err <= 1'b1;
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign sync_err  = r_sync_err;

endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Stream-to-memory writer for the zoom pipeline: accepts a raster pixel stream over a valid/ready handshake and writes it row-major into a single-port frame-buffer RAM. It is the store side of the pixel path: the ROM reader/zoom datapath produces pixels, and this block lands them in the output buffer that the display side reads. The frame size is set at runtime (zoomed output) and may be up to the compile-time maximum. The row pitch in memory is fixed at `STRIDE`.

## Interface
Parameters:
- `MAX_WIDTH`, default 640: maximum frame width in pixels.
- `MAX_HEIGHT`, default 480: maximum frame height in lines.
- `STRIDE`, default 640: memory words between line starts. Must be ≥ `MAX_WIDTH`.
- `BASE_ADDR`, default 0: address of pixel (0,0).
- `ADDR_WIDTH`, default 19: RAM address width. Must hold `BASE_ADDR + (MAX_HEIGHT-1)*STRIDE + MAX_WIDTH-1`.
- `DATA_WIDTH`, default 8: pixel width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `start`, in, 1: one-cycle pulse that arms a frame capture.
- `frame_w`, in, 10: frame width. Sampled on an accepted `start`.
- `frame_h`, in, 9: frame height. Sampled on an accepted `start`.
- `pix_data`, in, `DATA_WIDTH`: input pixel.
- `pix_valid`, in, 1: `pix_data`/`pix_sof` valid.
- `pix_sof`, in, 1: marks the first pixel of a frame.
- `pix_ready`, out, 1: block accepts a beat (`pix_valid & pix_ready`).
- `mem_we`, out, 1: RAM write enable.
- `mem_addr`, out, `ADDR_WIDTH`: RAM write address.
- `mem_wdata`, out, `DATA_WIDTH`: RAM write data.
- `busy`, out, 1: state is not IDLE.
- `frame_done`, out, 1: one-cycle pulse when the last pixel is written.
- `sync_err`, out, 1: sticky flag for an unexpected SOF. Cleared by an accepted `start`.

## Operation
FSM states are IDLE, WAIT_SOF, WRITE and DONE.

- **IDLE**
  - `pix_ready`=0.
  - An accepted `start` requires `1 ≤ frame_w ≤ MAX_WIDTH` and `1 ≤ frame_h ≤ MAX_HEIGHT`.
  - On an accepted `start`: latch the dimensions, clear `sync_err`, set x=0, y=0, row_base=`BASE_ADDR`, then go to WAIT_SOF.
  - A `start` with invalid dimensions is ignored; the block stays in IDLE.
- **WAIT_SOF**
  - `pix_ready`=1.
  - Accepted beats with `pix_sof`=0 are discarded (no write).
  - An accepted beat with `pix_sof`=1 is written at (0,0), then the block goes to WRITE.
  - Exception: if the frame is 1×1, that beat goes straight to DONE.
- **WRITE**
  - `pix_ready`=1.
  - Each accepted beat is written at `row_base + x`.
  - Counter update: if x == w-1, then x←0, y←y+1, row_base←row_base+`STRIDE`; otherwise x←x+1.
  - The beat at (w-1, h-1) goes to DONE.
  - An accepted beat with `pix_sof`=1 mid-frame sets `sync_err`, is written at (0,0), and the counters resync to (1,0) (or next row if w=1). The frame then continues from there.
- **DONE**
  - `pix_ready`=0 and `frame_done`=1 for one cycle, then IDLE.
- **General rules**
  - `start` outside IDLE is ignored.
  - Address arithmetic is incremental (add `STRIDE` per line); no multiplier is used.
  - x is 10 bits and y is 9 bits.
  - row_base is `ADDR_WIDTH` bits and never wraps under legal parameters.
  - Pixels beyond the frame cannot be accepted, because `pix_ready`=0 in DONE/IDLE.

## Timing
- Reset values: FSM=IDLE, `pix_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `frame_done`=0, `sync_err`=0. Internal counters are cleared.
- `pix_ready` is a Moore output (decoded from state only), with no combinational path from `pix_valid`.
- Write latency is 1 cycle. A beat accepted at edge N produces `mem_we`=1 with registered `mem_addr`/`mem_wdata` during cycle N+1. `mem_we`=0 in any cycle following a non-accepted or discarded beat.
- Throughput is 1 pixel/clock in WRITE.
- Last beat accepted at N: `frame_done`=1 during N+1, coincident with the final `mem_we`. `busy`=0 and IDLE from N+2.
- `busy` rises the cycle after an accepted `start`.
- If `rst` is asserted mid-frame, the block returns immediately to the reset values. A partially written frame is left as-is in RAM.

## Structure
- Shared package (`zoom_pkg`) holds:
  - the `MAX_WIDTH`/`MAX_HEIGHT` defaults;
  - the x/y counter widths;
  - the FSM state enum (`FBW_IDLE`, `FBW_WAIT_SOF`, `FBW_WRITE`, `FBW_DONE`).
- One sub-module is natural: `raster_addr_gen`. It contains the x/y/row_base counters and provides `last_col`/`last_pix` flags, with inputs `clear`, `step` and `resync`.
- The FSM and the output registers stay in the top-level block.

## Test plan
- **Basic 4×3 frame:** `start` with w=4, h=3, `STRIDE`=640, base 0, then 12 beats with SOF on the first → writes at addresses 0–3, 640–643, 1280–1283 with matching data; `frame_done` pulses once with the 12th write; `busy` falls 1 cycle later.
- **Pre-SOF garbage:** 5 beats with `pix_sof`=0 in WAIT_SOF, then a frame → no `mem_we` for the 5 beats; the first write lands at address 0.
- **Backpressure-free gaps:** `pix_valid` toggled 1010… over a 2×2 frame → exactly 4 writes at 0, 1, 640, 641; `mem_we` is low in the gap cycles.
- **Mid-frame SOF:** w=4, h=2; after 3 beats a beat with SOF arrives → `sync_err`=1, that beat is written at address 0, and the next beat is written at 1. `sync_err` holds until the next accepted `start`.
- **Invalid/ignored start:** `start` with w=0 or h=481 → `busy` stays 0. A `start` pulse during WRITE → no effect on the counters.
- **Reset mid-frame and 1×1 frame:** `rst` after 2 beats → all outputs return to their reset values next cycle. A 1×1 frame → a single write at `BASE_ADDR`, with `frame_done` in the same cycle as that write.
